noc_local_inject: RTL and testbench
===================================

NOC_LOCAL_INJECT -- requirements
Module: noc_local_inject

Interface
REQ-001 Parameter CREDITS, default 4: per-VC flit buffer depth of the router local input port; this is the credit reset value.
REQ-002 Parameter FIFO_DEPTH, default 4: depth of the local-side word FIFO (power of 2).
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 RST  in  1  asynchronous active-high reset.
REQ-006 MY_XPOS  in  2  own X coordinate; placed in head flit.
REQ-007 MY_YPOS  in  2  own Y coordinate; placed in head flit.
REQ-008 S_VALID  in  1  local word valid.
REQ-009 S_READY  out  1  local word accepted when S_VALID&S_READY.
REQ-010 S_DATA  in  32  payload word.
REQ-011 S_LAST  in  1  final word of packet.
REQ-012 S_DST  in  4  destination {X[3:2],Y[1:0]}; sampled only on the first word of a packet.
REQ-013 S_VCH  in  1  VC for the packet; sampled only on the first word.
REQ-014 ODATA  out  35  flit to router local input port (IDATA_4).
REQ-015 OVALID  out  1  flit valid, one cycle per flit.
REQ-016 OVCH  out  1  VC of the current flit.
REQ-017 IACK  in  2  per-VC credit return from router; one pulse = one credit.
REQ-018 ILCK  in  2  per-VC lock; VC held by another packet.
REQ-019 CREDIT_ERR  out  1  sticky: credit returned while counter already at CREDITS.
REQ-020 BUSY  out  1  high when FSM is not IDLE or FIFO is non-empty.

Function
REQ-021 Flit format SHALL be: [34:33] type (01 head, 00 body, 10 tail), [32] = 0, [31:0] payload.
REQ-022 Head payload SHALL be {dstX[1:0], dstY[1:0], MY_XPOS, MY_YPOS, 24'h0}, packed MSB first.
REQ-023 Each packet SHALL be emitted as one head flit, then one flit per word; the S_LAST word is type tail and all earlier words are type body.
REQ-024 FIFO SHALL store {last, vch, dst, data}; S_READY = !full (combinational); a push while full is impossible, with no pop bypass.
REQ-025 One credit counter per VC SHALL exist, range 0..CREDITS: send on VC v → -1; IACK[v] → +1; both in the same cycle → unchanged.
REQ-026 IACK[v] with counter at CREDITS → counter holds and CREDIT_ERR sets until reset.
REQ-027 FSM states SHALL be IDLE, HEAD, BODY.
REQ-028 IDLE: FIFO non-empty → latch front entry's dst/vch into pkt_dst/pkt_vc, go to HEAD.
REQ-029 HEAD: credit[pkt_vc]>0 and ILCK[pkt_vc]=0 → emit head, go to BODY; otherwise stall with OVALID=0.
REQ-030 BODY: FIFO non-empty and credit[pkt_vc]>0 → pop and emit the word; if its last=1 → go to IDLE; otherwise stall. ILCK is ignored in BODY.
REQ-031 ODATA, OVALID and OVCH SHALL be registered; OVALID=1 for exactly the cycle after the emitting edge; ODATA holds its last value when OVALID=0; OVCH=pkt_vc.
REQ-032 Latency: first word accepted at edge t → head flit OVALID in the cycle after edge t+2 (credits present, unlocked); body flits may follow back-to-back, one per cycle.
REQ-033 Throughput: one flit per cycle maximum; a packet of N words takes N+1 flit cycles plus the IDLE→HEAD cycle.
REQ-034 The VC of an in-flight packet SHALL never change; words already in the FIFO for the next packet SHALL wait until the current tail has been emitted.

Reset
REQ-035 On RST the block SHALL set: FSM=IDLE, FIFO empty, credits=CREDITS on both VCs, OVALID=0, ODATA=0, OVCH=0, CREDIT_ERR=0, BUSY=0, and S_READY=1 after release.
REQ-036 Reset mid-packet SHALL drop the partial packet and all FIFO contents; no tail is emitted and no packet resumes after release.

Verification
REQ-037 Single-word packet: S_DATA=32'hDEADBEEF, S_LAST=1, S_DST=4'b1001, S_VCH=0, MY_XPOS=2'b01, MY_YPOS=2'b10 → head ODATA={2'b01,1'b0,32'h9600_0000}, then tail {2'b10,1'b0,32'hDEADBEEF}, OVCH=0, credit[0]=2.
REQ-038 Credit stall: VC1, 6-word packet, no IACK → exactly 4 flits (head + 3 body), then OVALID=0; single IACK[1] pulse → exactly one more body flit.
REQ-039 Lock: ILCK[0]=1 with packet on VC0 → no head; ILCK[0] drops → head the next cycle; ILCK[0] reasserted mid-packet → body flits continue.
REQ-040 Simultaneous send and IACK on the same VC for 10 cycles → credit constant; IACK at credit=4 → CREDIT_ERR=1 and credit remains 4.
REQ-041 FIFO full: 5 words offered while the router is stalled (no credits) → S_READY=0 after 4 accepted words; S_READY returns 1 the cycle after the first pop.
REQ-042 RST pulse mid-body → the next cycle shows OVALID=0, BUSY=0, credits=4/4; a new packet after release begins with a head flit.

Source files
------------

// File: rtl/noc_local_inject_if.sv
// Bundle of the local word stream and the router local-port flit/credit
// signals. The injector uses the slave view, the local source plus the
// router side use the master view.
interface noc_local_inject_if;
    logic        S_VALID;
    logic        S_READY;
    logic [31:0] S_DATA;
    logic        S_LAST;
    logic [3:0]  S_DST;
    logic        S_VCH;
    logic [34:0] ODATA;
    logic        OVALID;
    logic        OVCH;
    logic [1:0]  IACK;
    logic [1:0]  ILCK;

    modport slave (
        input  S_VALID, S_DATA, S_LAST, S_DST, S_VCH, IACK, ILCK,
        output S_READY, ODATA, OVALID, OVCH
    );

    modport master (
        output S_VALID, S_DATA, S_LAST, S_DST, S_VCH, IACK, ILCK,
        input  S_READY, ODATA, OVALID, OVCH
    );
endinterface

// File: rtl/noc_local_inject.sv
// Local-port packet injector: buffers payload words in a small FIFO, wraps
// each packet as head + body/tail flits, and meters flits into the router
// with one credit counter per virtual channel.
module noc_local_inject #(
    parameter int CREDITS    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              RST,
    input  logic [1:0]        MY_XPOS,
    input  logic [1:0]        MY_YPOS,
    noc_local_inject_if.slave lif,
    output logic              CREDIT_ERR,
    output logic              BUSY
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(CREDITS + 1);
    localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);
    localparam int EW = 38;   // {last, vch, dst[3:0], data[31:0]}

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HEAD = 2'd1,
        BODY = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    pkt_dst_q, pkt_dst_d;
    logic          pkt_vc_q, pkt_vc_d;
    logic [34:0]   odata_q, odata_d;
    logic          ovalid_q, ovalid_d;
    logic          ovch_q, ovch_d;
    logic [CW-1:0] credit_q [2];
    logic [CW-1:0] credit_d [2];
    logic          err_q, err_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [EW-1:0] mem [FIFO_DEPTH];

    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic          send;
    logic [EW-1:0] front;
    logic          front_last;
    logic          front_vch;
    logic [3:0]    front_dst;
    logic [31:0]   front_data;
    logic          cur_has_credit;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // No pop bypass: a full FIFO refuses the word even if it pops this cycle.
    assign push       = lif.S_VALID && !fifo_full;

    assign front      = mem[rd_ptr_q[AW-1:0]];
    assign front_last = front[37];
    assign front_vch  = front[36];
    assign front_dst  = front[35:32];
    assign front_data = front[31:0];

    assign cur_has_credit = (credit_q[pkt_vc_q] != '0);

    assign lif.S_READY = !fifo_full;
    assign lif.ODATA   = odata_q;
    assign lif.OVALID  = ovalid_q;
    assign lif.OVCH    = ovch_q;
    assign CREDIT_ERR  = err_q;
    assign BUSY        = (state_q != IDLE) || !fifo_empty;

    // Packet framing: pick up the next packet, gate head on credit+lock,
    // then drain words while credit lasts until the tail word goes out.
    always_comb begin
        state_d   = state_q;
        pkt_dst_d = pkt_dst_q;
        pkt_vc_d  = pkt_vc_q;
        odata_d   = odata_q;
        ovalid_d  = 1'b0;
        ovch_d    = ovch_q;
        pop       = 1'b0;
        send      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pkt_dst_d = front_dst;
                    pkt_vc_d  = front_vch;
                    state_d   = HEAD;
                end
            end
            HEAD: begin
                if (cur_has_credit && !lif.ILCK[pkt_vc_q]) begin
                    send     = 1'b1;
                    ovalid_d = 1'b1;
                    ovch_d   = pkt_vc_q;
                    odata_d  = {2'b01, 1'b0, pkt_dst_q, MY_XPOS, MY_YPOS, 24'h0};
                    state_d  = BODY;
                end
            end
            BODY: begin
                // The VC lock only guards packet start; once the head is out
                // the VC belongs to this packet.
                if (!fifo_empty && cur_has_credit) begin
                    pop      = 1'b1;
                    send     = 1'b1;
                    ovalid_d = 1'b1;
                    ovch_d   = pkt_vc_q;
                    odata_d  = {(front_last ? 2'b10 : 2'b00), 1'b0, front_data};
                    if (front_last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Per-VC credit accounting; a return with nothing outstanding is flagged.
    always_comb begin
        err_d = err_q;
        for (int v = 0; v < 2; v++) begin
            credit_d[v] = credit_q[v];
            if (send && (pkt_vc_q == 1'(v)) && !lif.IACK[v]) begin
                credit_d[v] = credit_q[v] - CW'(1);
            end else if (lif.IACK[v] && !(send && (pkt_vc_q == 1'(v)))) begin
                if (credit_q[v] == CRED_MAX) begin
                    err_d = 1'b1;
                end else begin
                    credit_d[v] = credit_q[v] + CW'(1);
                end
            end
        end
    end

    // FIFO pointer advance.
    always_comb begin
        wr_ptr_d = wr_ptr_q + (push ? (AW+1)'(1) : '0);
        rd_ptr_d = rd_ptr_q + (pop  ? (AW+1)'(1) : '0);
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q[AW-1:0]] <= {lif.S_LAST, lif.S_VCH, lif.S_DST, lif.S_DATA};
        end
    end

    // All control state and registered flit outputs.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            pkt_dst_q <= '0;
            pkt_vc_q  <= 1'b0;
            odata_q   <= '0;
            ovalid_q  <= 1'b0;
            ovch_q    <= 1'b0;
            err_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            for (int v = 0; v < 2; v++) begin
                credit_q[v] <= CRED_MAX;
            end
        end else begin
            state_q   <= state_d;
            pkt_dst_q <= pkt_dst_d;
            pkt_vc_q  <= pkt_vc_d;
            odata_q   <= odata_d;
            ovalid_q  <= ovalid_d;
            ovch_q    <= ovch_d;
            err_q     <= err_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            for (int v = 0; v < 2; v++) begin
                credit_q[v] <= credit_d[v];
            end
        end
    end
endmodule

// File: tb/tb_noc_local_inject.sv
// Directed bench for noc_local_inject: packet framing, credit stall, VC lock,
// credit overflow, FIFO backpressure and mid-packet reset.
module tb_noc_local_inject;
    logic       clk;
    logic       rst;
    logic [1:0] my_x;
    logic [1:0] my_y;
    logic       credit_err;
    logic       busy;

    noc_local_inject_if lif();

    noc_local_inject #(.CREDITS(4), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .RST        (rst),
        .MY_XPOS    (my_x),
        .MY_YPOS    (my_y),
        .lif        (lif),
        .CREDIT_ERR (credit_err),
        .BUSY       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n_acc = 0;

    logic [37:0] feed_q [$];   // {last, vch, dst, data}
    logic [34:0] cap_q  [$];
    logic        capvc_q[$];

    // Present the front word of the feed queue (or idle the stream).
    task automatic drive_front();
        logic [37:0] e;
        if (feed_q.size() != 0) begin
            e = feed_q[0];
            lif.S_VALID = 1'b1;
            lif.S_LAST  = e[37];
            lif.S_VCH   = e[36];
            lif.S_DST   = e[35:32];
            lif.S_DATA  = e[31:0];
        end else begin
            lif.S_VALID = 1'b0;
        end
    endtask

    // One clock: account accepted words, capture emitted flits.
    task automatic cycle();
        logic acc;
        acc = lif.S_VALID && lif.S_READY;
        @(posedge clk);
        #1;
        if (acc) begin
            void'(feed_q.pop_front());
            n_acc++;
        end
        if (lif.OVALID) begin
            cap_q.push_back(lif.ODATA);
            capvc_q.push_back(lif.OVCH);
            $display("flit: type=%b data=%h vc=%0d", lif.ODATA[34:33], lif.ODATA[31:0], lif.OVCH);
        end
        drive_front();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic add_pkt(input int n, input logic vch, input logic [3:0] dst, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            feed_q.push_back({(i == n - 1), vch, dst, base + 32'(i)});
        end
        drive_front();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        feed_q.delete();
        drive_front();
        lif.IACK = 2'b00;
        lif.ILCK = 2'b00;
        run(2);
        rst = 1'b0;
        cap_q.delete();
        capvc_q.delete();
        n_acc = 0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (lif.OVALID !== 1'b0) begin bad++; $display("FAIL reset_ovalid: got %b exp 0", lif.OVALID); end
        total++; if (lif.ODATA !== 35'h0) begin bad++; $display("FAIL reset_odata: got %h exp 0", lif.ODATA); end
        total++; if (lif.OVCH !== 1'b0) begin bad++; $display("FAIL reset_ovch: got %b exp 0", lif.OVCH); end
        total++; if (credit_err !== 1'b0) begin bad++; $display("FAIL reset_cerr: got %b exp 0", credit_err); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b exp 0", busy); end
        total++; if (lif.S_READY !== 1'b1) begin bad++; $display("FAIL reset_sready: got %b exp 1", lif.S_READY); end
        total++; if (dut.credit_q[0] !== 3'd4 || dut.credit_q[1] !== 3'd4) begin bad++; $display("FAIL reset_credits: got %0d/%0d exp 4/4", dut.credit_q[0], dut.credit_q[1]); end
        $display("test_reset done");
    endtask

    task automatic test_single_word();
        do_reset();
        add_pkt(1, 1'b0, 4'b1001, 32'hDEADBEEF);
        cycle();   // edge t: word accepted
        total++; if (lif.OVALID !== 1'b0) begin bad++; $display("FAIL single_t0_ovalid: got %b exp 0", lif.OVALID); end
        cycle();   // t+1: IDLE->HEAD
        total++; if (lif.OVALID !== 1'b0) begin bad++; $display("FAIL single_t1_ovalid: got %b exp 0", lif.OVALID); end
        cycle();   // t+2: head
        total++; if (lif.OVALID !== 1'b1 || lif.ODATA !== {2'b01, 1'b0, 32'h9600_0000}) begin bad++; $display("FAIL single_head: got v=%b d=%h exp v=1 d=%h", lif.OVALID, lif.ODATA, {2'b01, 1'b0, 32'h9600_0000}); end
        total++; if (lif.OVCH !== 1'b0) begin bad++; $display("FAIL single_ovch: got %b exp 0", lif.OVCH); end
        cycle();   // tail
        total++; if (lif.OVALID !== 1'b1 || lif.ODATA !== {2'b10, 1'b0, 32'hDEADBEEF}) begin bad++; $display("FAIL single_tail: got v=%b d=%h exp v=1 d=%h", lif.OVALID, lif.ODATA, {2'b10, 1'b0, 32'hDEADBEEF}); end
        cycle();
        total++; if (lif.OVALID !== 1'b0 || lif.ODATA !== {2'b10, 1'b0, 32'hDEADBEEF}) begin bad++; $display("FAIL single_hold: got v=%b d=%h exp v=0 d held", lif.OVALID, lif.ODATA); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy: got %b exp 0", busy); end
        total++; if (dut.credit_q[0] !== 3'd2) begin bad++; $display("FAIL single_credit0: got %0d exp 2", dut.credit_q[0]); end
        $display("test_single_word done");
    endtask

    task automatic test_credit_stall();
        do_reset();
        add_pkt(6, 1'b1, 4'b0110, 32'hA000_0000);
        run(30);
        total++; if (cap_q.size() !== 4) begin bad++; $display("FAIL stall_count: got %0d exp 4", cap_q.size()); end
        if (cap_q.size() >= 4) begin
            total++; if (cap_q[0] !== {2'b01, 1'b0, 32'h6600_0000}) begin bad++; $display("FAIL stall_head: got %h exp %h", cap_q[0], {2'b01, 1'b0, 32'h6600_0000}); end
            total++; if (cap_q[3] !== {2'b00, 1'b0, 32'hA000_0002}) begin bad++; $display("FAIL stall_body3: got %h exp %h", cap_q[3], {2'b00, 1'b0, 32'hA000_0002}); end
            total++; if (capvc_q[3] !== 1'b1) begin bad++; $display("FAIL stall_vc: got %b exp 1", capvc_q[3]); end
        end
        lif.IACK = 2'b10;
        cycle();
        lif.IACK = 2'b00;
        run(10);
        total++; if (cap_q.size() !== 5) begin bad++; $display("FAIL stall_after_iack: got %0d exp 5", cap_q.size()); end
        if (cap_q.size() >= 5) begin
            total++; if (cap_q[4] !== {2'b00, 1'b0, 32'hA000_0003}) begin bad++; $display("FAIL stall_body4: got %h exp %h", cap_q[4], {2'b00, 1'b0, 32'hA000_0003}); end
        end
        $display("test_credit_stall done");
    endtask

    task automatic test_lock();
        do_reset();
        lif.ILCK = 2'b01;
        add_pkt(3, 1'b0, 4'b0000, 32'hB000_0000);
        run(8);
        total++; if (cap_q.size() !== 0) begin bad++; $display("FAIL lock_blocked: got %0d exp 0", cap_q.size()); end
        lif.ILCK = 2'b00;
        cycle();
        total++; if (lif.OVALID !== 1'b1 || lif.ODATA[34:33] !== 2'b01) begin bad++; $display("FAIL lock_head_next: got v=%b t=%b exp v=1 t=01", lif.OVALID, lif.ODATA[34:33]); end
        lif.ILCK = 2'b01;
        run(6);
        total++; if (cap_q.size() !== 4) begin bad++; $display("FAIL lock_body_count: got %0d exp 4", cap_q.size()); end
        if (cap_q.size() >= 4) begin
            total++; if (cap_q[3] !== {2'b10, 1'b0, 32'hB000_0002}) begin bad++; $display("FAIL lock_tail: got %h exp %h", cap_q[3], {2'b10, 1'b0, 32'hB000_0002}); end
        end
        lif.ILCK = 2'b00;
        $display("test_lock done");
    endtask

    task automatic test_simul_iack();
        do_reset();
        add_pkt(16, 1'b0, 4'b0101, 32'hC000_0000);
        for (int k = 0; k < 20 && cap_q.size() == 0; k++) cycle();
        total++; if (cap_q.size() !== 1) begin bad++; $display("FAIL simul_head_seen: got %0d exp 1", cap_q.size()); end
        lif.IACK = 2'b01;
        run(10);
        lif.IACK = 2'b00;
        total++; if (dut.credit_q[0] !== 3'd3) begin bad++; $display("FAIL simul_credit: got %0d exp 3", dut.credit_q[0]); end
        total++; if (cap_q.size() !== 11) begin bad++; $display("FAIL simul_flits: got %0d exp 11", cap_q.size()); end
        total++; if (credit_err !== 1'b0) begin bad++; $display("FAIL simul_cerr: got %b exp 0", credit_err); end
        do_reset();
        lif.IACK = 2'b01;
        cycle();
        lif.IACK = 2'b00;
        cycle();
        total++; if (credit_err !== 1'b1) begin bad++; $display("FAIL overflow_cerr: got %b exp 1", credit_err); end
        total++; if (dut.credit_q[0] !== 3'd4) begin bad++; $display("FAIL overflow_credit: got %0d exp 4", dut.credit_q[0]); end
        do_reset();
        total++; if (credit_err !== 1'b0) begin bad++; $display("FAIL overflow_clear: got %b exp 0", credit_err); end
        $display("test_simul_iack done");
    endtask

    task automatic test_fifo_full();
        do_reset();
        add_pkt(3, 1'b1, 4'b1111, 32'hD000_0000);
        run(10);
        total++; if (dut.credit_q[1] !== 3'd0 || cap_q.size() !== 4) begin bad++; $display("FAIL full_drain: got credit=%0d flits=%0d exp 0/4", dut.credit_q[1], cap_q.size()); end
        n_acc = 0;
        add_pkt(5, 1'b1, 4'b1111, 32'hE000_0000);
        run(10);
        total++; if (n_acc !== 4) begin bad++; $display("FAIL full_accepted: got %0d exp 4", n_acc); end
        total++; if (lif.S_READY !== 1'b0) begin bad++; $display("FAIL full_sready: got %b exp 0", lif.S_READY); end
        lif.IACK = 2'b10;
        cycle();
        lif.IACK = 2'b00;
        cycle();   // head consumes the returned credit, no pop
        total++; if (lif.S_READY !== 1'b0 || cap_q.size() !== 5) begin bad++; $display("FAIL full_after_head: got rdy=%b flits=%0d exp 0/5", lif.S_READY, cap_q.size()); end
        lif.IACK = 2'b10;
        cycle();
        lif.IACK = 2'b00;
        total++; if (lif.S_READY !== 1'b0) begin bad++; $display("FAIL full_before_pop: got %b exp 0", lif.S_READY); end
        cycle();   // first pop
        total++; if (lif.S_READY !== 1'b1) begin bad++; $display("FAIL full_after_pop: got %b exp 1", lif.S_READY); end
        cycle();
        total++; if (n_acc !== 5) begin bad++; $display("FAIL full_fifth: got %0d exp 5", n_acc); end
        $display("test_fifo_full done");
    endtask

    task automatic test_reset_mid();
        do_reset();
        add_pkt(6, 1'b0, 4'b1010, 32'hF000_0000);
        for (int k = 0; k < 20 && cap_q.size() < 3; k++) cycle();
        total++; if (cap_q.size() !== 3) begin bad++; $display("FAIL mid_progress: got %0d exp 3", cap_q.size()); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (lif.OVALID !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mid_rst_out: got v=%b busy=%b exp 0/0", lif.OVALID, busy); end
        total++; if (dut.credit_q[0] !== 3'd4 || dut.credit_q[1] !== 3'd4) begin bad++; $display("FAIL mid_rst_credits: got %0d/%0d exp 4/4", dut.credit_q[0], dut.credit_q[1]); end
        feed_q.delete();
        drive_front();
        cycle();
        rst = 1'b0;
        run(6);
        total++; if (cap_q.size() !== 3) begin bad++; $display("FAIL mid_no_resume: got %0d exp 3", cap_q.size()); end
        add_pkt(1, 1'b1, 4'b0011, 32'h1234_5678);
        for (int k = 0; k < 20 && cap_q.size() < 4; k++) cycle();
        cycle();
        total++; if (cap_q.size() !== 5) begin bad++; $display("FAIL mid_new_count: got %0d exp 5", cap_q.size()); end
        if (cap_q.size() >= 5) begin
            total++; if (cap_q[3] !== {2'b01, 1'b0, 32'h3600_0000}) begin bad++; $display("FAIL mid_new_head: got %h exp %h", cap_q[3], {2'b01, 1'b0, 32'h3600_0000}); end
            total++; if (cap_q[4] !== {2'b10, 1'b0, 32'h1234_5678}) begin bad++; $display("FAIL mid_new_tail: got %h exp %h", cap_q[4], {2'b10, 1'b0, 32'h1234_5678}); end
            total++; if (capvc_q[4] !== 1'b1) begin bad++; $display("FAIL mid_new_vc: got %b exp 1", capvc_q[4]); end
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        rst         = 1'b1;
        my_x        = 2'b01;
        my_y        = 2'b10;
        lif.S_VALID = 1'b0;
        lif.S_DATA  = '0;
        lif.S_LAST  = 1'b0;
        lif.S_DST   = '0;
        lif.S_VCH   = 1'b0;
        lif.IACK    = 2'b00;
        lif.ILCK    = 2'b00;
        test_reset();
        test_single_word();
        test_credit_stall();
        test_lock();
        test_simul_iack();
        test_fifo_full();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1, "timeout");
    end
endmodule
